// File: rtl/qdec_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states, Gray-code
// phase values and the (prev, cur) transition classifier.
package qdec_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    TR_HOLD,
    TR_UP,
    TR_DOWN,
    TR_ILLEGAL
  } trans_e;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  // Up order is 00 -> 01 -> 11 -> 10 -> 00; both bits flipping is illegal.
  function automatic trans_e classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_e tr;
    tr = TR_HOLD;
    if (prev == cur) begin
      tr = TR_HOLD;
    end else if ((prev ^ cur) == 2'b11) begin
      tr = TR_ILLEGAL;
    end else begin
      unique case (prev)
        AB_00:   tr = (cur == AB_01) ? TR_UP : TR_DOWN;
        AB_01:   tr = (cur == AB_11) ? TR_UP : TR_DOWN;
        AB_11:   tr = (cur == AB_10) ? TR_UP : TR_DOWN;
        default: tr = (cur == AB_00) ? TR_UP : TR_DOWN;
      endcase
    end
    return tr;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit synchronizer chain for an asynchronous input; clears to 0 on
// synchronous reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: synchronizes A/B, then emits step/dir pulses, a
// wrapping position count and a sticky illegal-transition flag.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int unsigned CW = $clog2(SYNC_STAGES + 1);

  logic qa_sync, qb_sync;
  logic [1:0] ab_s;

  state_e state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic [1:0] prev_ab_q, prev_ab_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic dir_q, dir_d, step_q, step_d, err_q, err_d;
  logic err_set;
  trans_e tr;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(qa), .q(qa_sync));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(qb), .q(qb_sync));

  assign ab_s = {qa_sync, qb_sync};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    count_d    = count_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_set    = 1'b0;
    tr         = classify(prev_ab_q, ab_s);

    unique case (state_q)
      ST_INIT: begin
        // First synchronized sample is absorbed so idle pins never count.
        if (init_cnt_q == '0) begin
          prev_ab_d = ab_s;
          state_d   = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q - CW'(1);
        end
      end
      default: begin
        prev_ab_d = ab_s;
        unique case (tr)
          TR_UP: begin
            count_d = count_q + WIDTH'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
          end
          TR_DOWN: begin
            count_d = count_q - WIDTH'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
          end
          TR_ILLEGAL: err_set = 1'b1;
          default: ;
        endcase
      end
    endcase

    // A new illegal transition wins over a simultaneous clear.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= CW'(SYNC_STAGES);
      prev_ab_q  <= AB_00;
      count_q    <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: table vectors, hand-written corner sequences and
// random pin activity, all checked every cycle against a phase-position model.
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int SS    = 2;
  localparam int MOD   = 1 << WIDTH;

  logic clk = 1'b0;
  logic reset, qa, qb, err_clr;
  logic [WIDTH-1:0] count;
  logic dir, step, err;

  always #5 clk = ~clk;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err)
  );

  int total = 0;
  int bad = 0;

  // Reference model: pins sampled per edge; a transition seen at pins edge
  // k-3 -> k-2 shows up on the outputs after edge k, once INIT has passed.
  int m_count = 0;
  logic m_dir = 1'b0, m_step = 1'b0, m_err = 1'b0;
  int since = 0;
  logic [1:0] h [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int pos(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gray[i] == ab) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    int d;
    logic ill;
    @(posedge clk);
    for (int i = 3; i > 0; i--) h[i] = h[i-1];
    h[0] = {qa, qb};
    if (reset) begin
      m_count = 0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0; since = 0;
    end else begin
      ill = 1'b0;
      m_step = 1'b0;
      if (since < 100) since++;
      if (since >= SS + 2) begin
        d = (pos(h[2]) - pos(h[3]) + 4) % 4;
        if (d == 1) begin
          m_count = (m_count + 1) % MOD; m_dir = 1'b1; m_step = 1'b1;
        end else if (d == 3) begin
          m_count = (m_count + MOD - 1) % MOD; m_dir = 1'b0; m_step = 1'b1;
        end else if (d == 2) begin
          ill = 1'b1;
        end
      end
      if (ill) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    #1;
    check("count", 32'(count), 32'(m_count));
    check("dir", 32'(dir), 32'(m_dir));
    check("step", 32'(step), 32'(m_step));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic move(input logic [1:0] ab);
    {qa, qb} = ab;
    repeat (4) tick();
  endtask

  typedef struct {
    logic [1:0] ab;
    logic       clr;
    int         cnt;
    logic       dr;
    logic       er;
  } vec_t;

  vec_t tbl [13];
  logic [1:0] cur;
  int r;

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 1,  1'b1, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 2,  1'b1, 1'b0};
    tbl[2]  = '{2'b10, 1'b0, 3,  1'b1, 1'b0};
    tbl[3]  = '{2'b00, 1'b0, 4,  1'b1, 1'b0};
    tbl[4]  = '{2'b10, 1'b0, 3,  1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b0, 2,  1'b0, 1'b0};
    tbl[6]  = '{2'b01, 1'b0, 1,  1'b0, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 0,  1'b0, 1'b0};
    tbl[8]  = '{2'b10, 1'b0, 15, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 1'b0, 0,  1'b1, 1'b0};
    tbl[10] = '{2'b01, 1'b0, 1,  1'b1, 1'b0};
    tbl[11] = '{2'b10, 1'b0, 1,  1'b1, 1'b1};
    tbl[12] = '{2'b10, 1'b1, 1,  1'b1, 1'b0};

    reset = 1'b1; qa = 1'b0; qb = 1'b0; err_clr = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    repeat (6) tick();
    check("idle_count", 32'(count), 32'd0);
    check("idle_step", 32'(step), 32'd0);

    for (int i = 0; i < 13; i++) begin
      {qa, qb} = tbl[i].ab;
      err_clr = tbl[i].clr;
      tick();
      err_clr = 1'b0;
      repeat (3) tick();
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_dir", i), 32'(dir), 32'(tbl[i].dr));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
    end

    // Clear coincides with a fresh illegal 10 -> 01: set must win.
    {qa, qb} = 2'b01;
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_vs_set_err", 32'(err), 32'd1);
    check("clr_vs_set_count", 32'(count), 32'd1);
    tick();

    // Reset with pins at 10, climb to 7 ending on 11, then reset mid-run.
    {qa, qb} = 2'b10;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    move(2'b00); move(2'b01); move(2'b11); move(2'b10);
    move(2'b00); move(2'b01); move(2'b11);
    check("run7_count", 32'(count), 32'd7);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    check("rst11_count", 32'(count), 32'd0);
    check("rst11_err", 32'(err), 32'd0);
    move(2'b10);
    check("after_rst_count", 32'(count), 32'd1);
    check("after_rst_dir", 32'(dir), 32'd1);

    cur = 2'b10;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      reset = (r < 2);
      r = $urandom_range(0, 99);
      if (r >= 45 && r < 70) cur = gray[(pos(cur) + 1) % 4];
      else if (r >= 70 && r < 95) cur = gray[(pos(cur) + 3) % 4];
      else if (r >= 95) cur = cur ^ 2'b11;
      {qa, qb} = cur;
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;
    err_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
